// File: rtl/rv32i_instr_encoder.sv
// Program-load encoder: turns decoded RV32I field records into machine words
// and writes them to instruction memory at sequential addresses from a base.
module rv32i_instr_encoder #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_class,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] CLS_LOAD   = 3'd0;
  localparam logic [2:0] CLS_STORE  = 3'd1;
  localparam logic [2:0] CLS_RTYPE  = 3'd2;
  localparam logic [2:0] CLS_ITYPE  = 3'd3;
  localparam logic [2:0] CLS_BRANCH = 3'd4;

  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  cur_addr;
  logic [CNT_W-1:0]   count;
  logic               last_q;

  logic [31:0]        enc_word_c;
  logic               enc_legal_c;
  logic               imm12_ok_c;
  logic               imm13_ok_c;
  logic               shamt_ok_c;
  logic               is_shift_c;
  logic               br_f3_ok_c;

  // Immediate range checks: value fits when all bits above the field match its sign bit.
  always_comb begin
    imm12_ok_c = (&in_imm[31:11]) | (~|in_imm[31:11]);
    imm13_ok_c = (&in_imm[31:12]) | (~|in_imm[31:12]);
    shamt_ok_c = ~|in_imm[31:5];
    is_shift_c = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);
    br_f3_ok_c = (in_funct3 == 3'b000) || (in_funct3 == 3'b001) || (in_funct3 == 3'b100);
  end

  // Field packing per instruction class, with legality of the record.
  always_comb begin
    enc_word_c  = '0;
    enc_legal_c = 1'b0;
    case (in_class)
      CLS_LOAD: begin
        enc_word_c  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        enc_legal_c = imm12_ok_c;
      end
      CLS_STORE: begin
        enc_word_c  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        enc_legal_c = imm12_ok_c;
      end
      CLS_RTYPE: begin
        enc_word_c  = {1'b0, in_funct7b, 5'b00000, in_rs2, in_rs1, in_funct3, in_rd, OP_RTYPE};
        enc_legal_c = 1'b1;
      end
      CLS_ITYPE: begin
        if (is_shift_c) begin
          enc_word_c  = {1'b0, in_funct7b, 5'b00000, in_imm[4:0], in_rs1, in_funct3, in_rd,
                         OP_ITYPE};
          enc_legal_c = shamt_ok_c;
        end else begin
          enc_word_c  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_ITYPE};
          enc_legal_c = imm12_ok_c;
        end
      end
      CLS_BRANCH: begin
        enc_word_c  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1],
                       in_imm[11], OP_BRANCH};
        enc_legal_c = imm13_ok_c & ~in_imm[0] & br_f3_ok_c;
      end
      default: begin
        enc_word_c  = '0;
        enc_legal_c = 1'b0;
      end
    endcase
  end

  // Session FSM; all outputs are registered and pulse strobes default low each cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      count     <= '0;
      last_q    <= 1'b0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= {base_addr[ADDR_W-1:2], 2'b00};
            count     <= '0;
            err       <= 1'b0;
            err_count <= '0;
            in_ready  <= 1'b1;
            state     <= ACCEPT;
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            if (enc_legal_c) begin
              mem_wdata <= enc_word_c;
              mem_addr  <= cur_addr;
              mem_we    <= 1'b1;
              last_q    <= in_last;
              in_ready  <= 1'b0;
              state     <= WRITE;
            end else begin
              err <= 1'b1;
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              if (in_last) begin
                in_ready <= 1'b0;
                done     <= 1'b1;
                state    <= DONE;
              end
            end
          end
        end
        WRITE: begin
          cur_addr <= cur_addr + ADDR_W'(4);
          count    <= count + CNT_W'(1);
          if (last_q || (count == CNT_W'(DEPTH - 1))) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            in_ready <= 1'b1;
            state    <= ACCEPT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Directed bench for rv32i_instr_encoder: table of field records with
// hand-encoded words, plus capacity, illegal-last and mid-session reset sequences.
module tb_rv32i_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  base_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [2:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_funct7b;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        done;
  logic        err;
  logic [7:0]  err_count;

  always #5 clk = ~clk;

  rv32i_instr_encoder #(.ADDR_W(8), .DEPTH(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_last    (in_last),
    .in_class   (in_class),
    .in_funct3  (in_funct3),
    .in_funct7b (in_funct7b),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_imm     (in_imm),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .done       (done),
    .err        (err),
    .err_count  (err_count)
  );

  typedef struct {
    logic [2:0]  cls;
    logic [2:0]  f3;
    logic        f7b;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        legal;
    logic [31:0] word;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  int          checks = 0;
  int          errors = 0;
  int          wcount = 0;
  logic [7:0]  exp_addr;
  logic [7:0]  exp_ec;

  always @(negedge clk) if (mem_we === 1'b1) wcount++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic pulse_start(input logic [7:0] b);
    start     = 1'b1;
    base_addr = b;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  // Waits (bounded) for in_ready, handshakes one record, then checks the cycle after.
  task automatic do_rec(input string tag, input vec_t r, input logic last);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
    in_valid   = 1'b1;
    in_last    = last;
    in_class   = r.cls;
    in_funct3  = r.f3;
    in_funct7b = r.f7b;
    in_rd      = r.rd;
    in_rs1     = r.rs1;
    in_rs2     = r.rs2;
    in_imm     = r.imm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (r.legal) begin
      chk({tag, "_we"}, 32'(mem_we), 32'd1);
      chk({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
      chk({tag, "_wdata"}, mem_wdata, r.word);
      chk({tag, "_rdy_low"}, 32'(in_ready), 32'd0);
      exp_addr = exp_addr + 8'd4;
    end else begin
      if (exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
      chk({tag, "_nowe"}, 32'(mem_we), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'd1);
      chk({tag, "_errcnt"}, 32'(err_count), 32'(exp_ec));
      if (!last) chk({tag, "_rdy_stay"}, 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   w0;

    //            cls   f3    f7b   rd     rs1    rs2    imm            legal word
    tbl[0]  = '{3'd0, 3'd2, 1'b0, 5'd6,  5'd9,  5'd0,  32'hFFFF_FFFC, 1'b1, 32'hFFC4A303};
    tbl[1]  = '{3'd1, 3'd2, 1'b0, 5'd0,  5'd9,  5'd6,  32'd8,         1'b1, 32'h0064A423};
    tbl[2]  = '{3'd4, 3'd0, 1'b0, 5'd0,  5'd4,  5'd4,  32'hFFFF_FFF8, 1'b1, 32'hFE420CE3};
    tbl[3]  = '{3'd4, 3'd0, 1'b0, 5'd0,  5'd4,  5'd4,  32'hFFFF_FFF9, 1'b0, 32'h0};
    tbl[4]  = '{3'd3, 3'd0, 1'b0, 5'd5,  5'd0,  5'd0,  32'd10,        1'b1, 32'h00A00293};
    tbl[5]  = '{3'd3, 3'd0, 1'b0, 5'd5,  5'd0,  5'd0,  32'd2048,      1'b0, 32'h0};
    tbl[6]  = '{3'd4, 3'd2, 1'b0, 5'd0,  5'd1,  5'd2,  32'd8,         1'b0, 32'h0};
    tbl[7]  = '{3'd3, 3'd1, 1'b0, 5'd1,  5'd2,  5'd0,  32'd3,         1'b1, 32'h00311093};
    tbl[8]  = '{3'd3, 3'd5, 1'b1, 5'd3,  5'd4,  5'd0,  32'd5,         1'b1, 32'h40525193};
    tbl[9]  = '{3'd3, 3'd1, 1'b0, 5'd1,  5'd2,  5'd0,  32'd32,        1'b0, 32'h0};
    tbl[10] = '{3'd5, 3'd0, 1'b0, 5'd1,  5'd2,  5'd3,  32'd0,         1'b0, 32'h0};
    tbl[11] = '{3'd0, 3'd0, 1'b0, 5'd1,  5'd2,  5'd0,  32'hFFFF_F800, 1'b1, 32'h80010083};
    tbl[12] = '{3'd0, 3'd0, 1'b0, 5'd1,  5'd2,  5'd0,  32'hFFFF_F7FF, 1'b0, 32'h0};
    tbl[13] = '{3'd1, 3'd0, 1'b0, 5'd0,  5'd2,  5'd1,  32'hFFFF_FFFF, 1'b1, 32'hFE110FA3};
    tbl[14] = '{3'd4, 3'd4, 1'b0, 5'd0,  5'd1,  5'd2,  32'd4094,      1'b1, 32'h7E20CFE3};
    tbl[15] = '{3'd4, 3'd4, 1'b0, 5'd0,  5'd1,  5'd2,  32'd4096,      1'b0, 32'h0};
    tbl[16] = '{3'd2, 3'd0, 1'b1, 5'd1,  5'd2,  5'd3,  32'd0,         1'b1, 32'h403100B3};
    tbl[17] = '{3'd2, 3'd6, 1'b0, 5'd4,  5'd5,  5'd6,  32'd0,         1'b1, 32'h0062E233};

    reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
    in_class = '0; in_funct3 = '0; in_funct7b = 1'b0; in_rd = '0; in_rs1 = '0;
    in_rs2 = '0; in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_errcnt", 32'(err_count), 32'd0);

    // Session 1: whole table, last record carries in_last.
    exp_addr = 8'h10; exp_ec = 8'd0;
    pulse_start(8'h10);
    for (int i = 0; i < NVEC; i++)
      do_rec($sformatf("vec%0d", i), tbl[i], (i == NVEC - 1));
    @(posedge clk); #1;
    chk("s1_done", 32'(done), 32'd1);
    chk("s1_we_low", 32'(mem_we), 32'd0);
    chk("s1_hold_wdata", mem_wdata, 32'h0062E233);
    chk("s1_hold_addr", 32'(mem_addr), 32'h38);
    @(posedge clk); #1;
    chk("s1_done_end", 32'(done), 32'd0);
    chk("s1_idle_ready", 32'(in_ready), 32'd0);
    chk("s1_err", 32'(err), 32'd1);
    chk("s1_errcnt", 32'(err_count), 32'd7);

    // Session 2: unaligned base, start ignored mid-session, illegal record ends session.
    exp_addr = 8'h40; exp_ec = 8'd0;
    pulse_start(8'h43);
    chk("s2_err_clr", 32'(err), 32'd0);
    chk("s2_errcnt_clr", 32'(err_count), 32'd0);
    pulse_start(8'h80);
    do_rec("s2_load", tbl[0], 1'b0);
    do_rec("s2_badlast", tbl[3], 1'b1);
    chk("s2_done", 32'(done), 32'd1);
    chk("s2_rdy", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("s2_done_end", 32'(done), 32'd0);

    // Session 3: capacity limit with address wrap, no in_last.
    exp_addr = 8'hF8; exp_ec = 8'd0;
    pulse_start(8'hF8);
    w0 = wcount;
    for (int k = 0; k < 64; k++) begin
      v.cls = 3'd3; v.f3 = 3'd0; v.f7b = 1'b0; v.rd = 5'(k); v.rs1 = 5'd0; v.rs2 = 5'd0;
      v.imm = 32'(k); v.legal = 1'b1;
      v.word = {12'(k), 5'd0, 3'd0, 5'(k), 7'h13};
      do_rec($sformatf("cap%0d", k), v, 1'b0);
    end
    @(posedge clk); #1;
    chk("cap_done", 32'(done), 32'd1);
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("cap_idle_ready", 32'(in_ready), 32'd0);
    chk("cap_done_end", 32'(done), 32'd0);
    chk("cap_wcount", 32'(wcount - w0), 32'd64);

    // Session 4: reset during WRITE aborts the session.
    exp_addr = 8'h00; exp_ec = 8'd0;
    pulse_start(8'h00);
    do_rec("r_bad", tbl[3], 1'b0);
    do_rec("r_good", tbl[4], 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("r_we", 32'(mem_we), 32'd0);
    chk("r_ready", 32'(in_ready), 32'd0);
    chk("r_err", 32'(err), 32'd0);
    chk("r_errcnt", 32'(err_count), 32'd0);
    w0 = wcount;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("r_nodone%0d", c), 32'(done), 32'd0);
      @(posedge clk); #1;
    end
    chk("r_no_write", 32'(wcount - w0), 32'd0);
    chk("r_idle_ready", 32'(in_ready), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
